// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - register file write-port arbiter for ALU and load-return results
//
// Purpose: merges ALU results and buffered load returns onto the single
// register file write port. Load returns sit in a DEPTH-entry FIFO so the
// load unit is not stalled while the ALU writes. The ALU normally wins the
// port. With WB_STARVE_GUARD_EN defined, a starve counter limits how many
// consecutive cycles the FIFO head can be bypassed.
//
// Optional feature macro: WB_STARVE_GUARD_EN
//
// Ports:
//   clk, rst       - clock; synchronous active-high reset
//   alu_valid/rd/data, alu_ready - ALU result handshake (ready is combinational)
//   ld_valid/rd/data, ld_ready   - load-return handshake into the FIFO (ready = !full)
//   RegWrite, rd, Write_data     - registered register file write port
//   pending_mask   - bit k set while any buffered load targets register k
//   fifo_count     - number of occupied FIFO entries
module writeback_arbiter #(
    parameter int n            = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [n-1:0]             alu_data,
    output logic                     alu_ready,
    input  logic                     ld_valid,
    input  logic [4:0]               ld_rd,
    input  logic [n-1:0]             ld_data,
    output logic                     ld_ready,
    output logic                     RegWrite,
    output logic [4:0]               rd,
    output logic [n-1:0]             Write_data,
    output logic [31:0]              pending_mask,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
        $error("writeback_arbiter: illegal DEPTH or STARVE_LIMIT");
    end

    // FIFO storage and pointers
    logic [4:0]   fifo_rd_q   [DEPTH];
    logic [4:0]   fifo_rd_d   [DEPTH];
    logic [n-1:0] fifo_data_q [DEPTH];
    logic [n-1:0] fifo_data_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Write port registers
    logic         regwrite_q, regwrite_d;
    logic [4:0]   rd_q, rd_d;
    logic [n-1:0] write_data_q, write_data_d;

    logic fifo_empty;
    logic push;
    logic pop;
    logic sel_alu;
    logic starve_fire;

    assign fifo_empty = (count_q == '0);
    assign ld_ready   = (count_q != CW'(DEPTH));
    // Reset cycles discard any handshake, so nothing enters the FIFO.
    assign push       = ld_valid && ld_ready && !rst;

`ifdef WB_STARVE_GUARD_EN
    logic [3:0] sc_q, sc_d;

    assign starve_fire = (sc_q == 4'(STARVE_LIMIT)) && !fifo_empty;

    // Counts consecutive ALU wins over a waiting FIFO head; any pop or an
    // empty FIFO restarts the count.
    always_comb begin
        sc_d = sc_q;
        if (fifo_empty || pop) begin
            sc_d = '0;
        end else if (sel_alu && sc_q != 4'(STARVE_LIMIT)) begin
            sc_d = sc_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sc_q <= '0;
        end else begin
            sc_q <= sc_d;
        end
    end
`else
    assign starve_fire = 1'b0;
`endif

    assign alu_ready = !starve_fire;
    assign sel_alu   = !starve_fire && alu_valid;
    assign pop       = starve_fire || (!alu_valid && !fifo_empty);

    // FIFO bookkeeping
    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push) begin
            fifo_rd_d[wr_ptr_q]   = ld_rd;
            fifo_data_d[wr_ptr_q] = ld_data;
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Write port selection. Destination x0 is consumed without a write, and
    // rd/Write_data keep their previous values whenever no write happens.
    always_comb begin
        regwrite_d   = 1'b0;
        rd_d         = rd_q;
        write_data_d = write_data_q;
        if (sel_alu) begin
            if (alu_rd != 5'd0) begin
                regwrite_d   = 1'b1;
                rd_d         = alu_rd;
                write_data_d = alu_data;
            end
        end else if (pop) begin
            if (fifo_rd_q[rd_ptr_q] != 5'd0) begin
                regwrite_d   = 1'b1;
                rd_d         = fifo_rd_q[rd_ptr_q];
                write_data_d = fifo_data_q[rd_ptr_q];
            end
        end
    end

    // Occupied entries are the count_q slots starting at the read pointer.
    always_comb begin
        pending_mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count_q) begin
                pending_mask[fifo_rd_q[rd_ptr_q + PW'(k)]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            regwrite_q   <= 1'b0;
            rd_q         <= '0;
            write_data_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            regwrite_q   <= regwrite_d;
            rd_q         <= rd_d;
            write_data_q <= write_data_d;
        end
    end

    // Entry contents need no reset; only slots counted by count_q are read.
    always_ff @(posedge clk) begin
        fifo_rd_q   <= fifo_rd_d;
        fifo_data_q <= fifo_data_d;
    end

    assign RegWrite   = regwrite_q;
    assign rd         = rd_q;
    assign Write_data = write_data_q;
    assign fifo_count = count_q;

endmodule
